// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit-side blocks: FSM state encoding
// and default sizing.
package uart_pkg;

    localparam int DATA_W_DEFAULT  = 8;
    localparam int TIMEOUT_DEFAULT = 1023;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SEND      = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_HOLD      = 3'd4
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request after ptr,
// wrapping modulo N. ptr itself is considered last.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          found,
    output logic [IW-1:0] idx
);

    always_comb begin
        logic [IW-1:0] cand;
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        // Walk offsets from farthest to nearest so the nearest hit wins.
        for (int k = N; k >= 1; k--) begin
            cand = IW'((int'(ptr) + k) % N);
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one UART TX engine among
// NUM_REQ byte producers, with a watchdog on an unresponsive engine/owner.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = DATA_W_DEFAULT,
    parameter int TIMEOUT = TIMEOUT_DEFAULT,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    input  logic [NUM_REQ-1:0]          req_last,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        tx_start,
    output logic [DATA_W-1:0]           tx_data,
    input  logic                        tx_busy,
    output logic                        grant_valid,
    output logic [IDX_W-1:0]            grant_id,
    output logic                        timeout_err
);

    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    grant_id_q, grant_id_d;
    logic                grant_valid_q, grant_valid_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic                last_flag_q, last_flag_d;
    logic [WD_W-1:0]     wdog_q, wdog_d;
    logic                tx_start_q, tx_start_d;
    logic [DATA_W-1:0]   tx_data_q, tx_data_d;
    logic [NUM_REQ-1:0]  req_ready_q, req_ready_d;
    logic                timeout_err_q, timeout_err_d;

    logic [DATA_W-1:0]   data_arr [NUM_REQ];
    logic                pick_found;
    logic [IDX_W-1:0]    pick_idx;
    logic [WD_W-1:0]     wdog_inc;
    logic                wd_expire;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign data_arr[g] = req_data[g*DATA_W +: DATA_W];
    end

    rr_pick #(.N(NUM_REQ), .IW(IDX_W)) u_rr_pick (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Saturating watchdog; expiry is flagged on the cycle the count reaches TIMEOUT.
    assign wdog_inc  = (wdog_q == WD_MAX) ? WD_MAX : wdog_q + 1'b1;
    assign wd_expire = (wdog_inc == WD_MAX);

    always_comb begin
        logic pkt_done;
        logic pkt_abort;
        state_d       = state_q;
        grant_id_d    = grant_id_q;
        grant_valid_d = grant_valid_q;
        rr_ptr_d      = rr_ptr_q;
        last_flag_d   = last_flag_q;
        wdog_d        = wdog_q;
        tx_start_d    = 1'b0;
        tx_data_d     = tx_data_q;
        req_ready_d   = '0;
        timeout_err_d = 1'b0;
        pkt_done      = 1'b0;
        pkt_abort     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    grant_id_d    = pick_idx;
                    grant_valid_d = 1'b1;
                    state_d       = ST_SEND;
                end
            end
            ST_SEND: begin
                tx_data_d               = data_arr[grant_id_q];
                tx_start_d              = 1'b1;
                req_ready_d[grant_id_q] = 1'b1;
                last_flag_d             = req_last[grant_id_q];
                wdog_d                  = '0;
                state_d                 = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end else begin
                    wdog_d    = wdog_inc;
                    pkt_abort = wd_expire;
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    if (last_flag_q) begin
                        pkt_done = 1'b1;
                    end else if (req_valid[grant_id_q]) begin
                        state_d = ST_SEND;
                    end else begin
                        wdog_d  = '0;
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                // Packet is still open: only the owner can continue it.
                if (req_valid[grant_id_q]) begin
                    state_d = ST_SEND;
                end else begin
                    wdog_d    = wdog_inc;
                    pkt_abort = wd_expire;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (pkt_done || pkt_abort) begin
            grant_valid_d = 1'b0;
            rr_ptr_d      = grant_id_q;
            state_d       = ST_IDLE;
        end
        timeout_err_d = pkt_abort;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            grant_id_q    <= '0;
            grant_valid_q <= 1'b0;
            rr_ptr_q      <= IDX_W'(NUM_REQ - 1);
            last_flag_q   <= 1'b0;
            wdog_q        <= '0;
            tx_start_q    <= 1'b0;
            tx_data_q     <= '0;
            req_ready_q   <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_id_q    <= grant_id_d;
            grant_valid_q <= grant_valid_d;
            rr_ptr_q      <= rr_ptr_d;
            last_flag_q   <= last_flag_d;
            wdog_q        <= wdog_d;
            tx_start_q    <= tx_start_d;
            tx_data_q     <= tx_data_d;
            req_ready_q   <= req_ready_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;
    assign grant_valid = grant_valid_q;
    assign grant_id    = grant_id_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: producer queues, a small UART engine
// model and a scoreboard of expected {grant_id, byte} per tx_start.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int TO = 1023;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_last;
    logic [N-1:0]      req_ready;
    logic              tx_start;
    logic [DW-1:0]     tx_data;
    logic              tx_busy;
    logic              grant_valid;
    logic [1:0]        grant_id;
    logic              timeout_err;

    uart_tx_arbiter #(.NUM_REQ(N), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .timeout_err (timeout_err)
    );

    logic [8:0]  pq [N][$];   // per-producer bytes {last, data}
    logic [9:0]  exp_q [$];   // expected {grant_id, data} per tx_start
    int npass = 0;
    int ntotal = 0;
    int cyc = 0;
    int tx_cnt = 0;
    int to_cnt = 0;
    int last_start_cyc = 0;
    int last_to_cyc = 0;
    bit eng_on = 1'b1;
    bit eng_pend = 1'b0;
    int eng_delay = 2;
    int eng_len = 10;
    int eng_wait = 0;
    int eng_rem = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive_prod();
        for (int i = 0; i < N; i++) begin
            req_valid[i] = (pq[i].size() != 0);
            if (pq[i].size() != 0) begin
                req_data[i*DW +: DW] = pq[i][0][7:0];
                req_last[i]          = pq[i][0][8];
            end else begin
                req_data[i*DW +: DW] = '0;
                req_last[i]          = 1'b0;
            end
        end
    endtask

    task automatic cycle();
        logic [9:0] e;
        @(negedge clk);
        cyc++;
        if (tx_start) begin
            chk("start_while_busy", {30'd0, tx_busy, eng_pend}, 32'd0);
            chk("req_ready_onehot", {28'd0, req_ready}, 32'd1 << grant_id);
            if (exp_q.size() == 0) begin
                chk("stray_tx_start", 32'(tx_start), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("tx_id_data", {22'd0, grant_id, tx_data}, {22'd0, e});
            end
            tx_cnt++;
            last_start_cyc = cyc;
        end else if (req_ready != '0) begin
            chk("stray_req_ready", {28'd0, req_ready}, 32'd0);
        end
        if (timeout_err) begin
            to_cnt++;
            last_to_cyc = cyc;
        end
        for (int i = 0; i < N; i++)
            if (req_ready[i] && pq[i].size() != 0) void'(pq[i].pop_front());
        if (eng_pend) begin
            if (eng_wait == 0) begin
                tx_busy  = 1'b1;
                eng_pend = 1'b0;
                eng_rem  = eng_len;
            end else begin
                eng_wait--;
            end
        end else if (eng_rem > 0) begin
            eng_rem--;
            if (eng_rem == 0) tx_busy = 1'b0;
        end
        if (tx_start && eng_on) begin
            eng_pend = 1'b1;
            eng_wait = eng_delay;
        end
        drive_prod();
    endtask

    task automatic drain(input string tag, input int lim);
        int n = 0;
        cycle();
        while (!(exp_q.size() == 0 && !grant_valid && !tx_busy && !eng_pend) && n < lim) begin
            cycle();
            n++;
        end
        chk({tag, "_drained"}, 32'(n < lim), 32'd1);
    endtask

    task automatic wait_start(input string tag, input int lim);
        int t0 = tx_cnt;
        int n = 0;
        while (tx_cnt == t0 && n < lim) begin
            cycle();
            n++;
        end
        chk({tag, "_start_seen"}, 32'(tx_cnt != t0), 32'd1);
    endtask

    task automatic wait_timeout(input string tag, input int lim);
        int t0 = to_cnt;
        int n = 0;
        while (to_cnt == t0 && n < lim) begin
            cycle();
            n++;
        end
        chk({tag, "_timeout_seen"}, 32'(to_cnt != t0), 32'd1);
    endtask

    task automatic reset_pulse();
        rst = 1'b0;
        cycle();
        cycle();
        rst = 1'b1;
        cycle();
    endtask

    initial begin
        int n;
        int t0;
        int to0;
        int st;
        bit busy_seen;
        rst     = 1'b0;
        tx_busy = 1'b0;
        drive_prod();
        repeat (3) cycle();
        chk("rst_req_ready", {28'd0, req_ready}, 32'd0);
        chk("rst_tx_start", 32'(tx_start), 32'd0);
        chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
        chk("rst_grant_valid", 32'(grant_valid), 32'd0);
        chk("rst_grant_id", {30'd0, grant_id}, 32'd0);
        chk("rst_timeout_err", 32'(timeout_err), 32'd0);
        rst = 1'b1;
        repeat (2) cycle();

        // single last byte, latency and release after busy falls
        t0 = tx_cnt;
        pq[0].push_back({1'b1, 8'h47});
        exp_q.push_back({2'd0, 8'h47});
        cycle();
        n = 0;
        while (!tx_start && n < 20) begin
            cycle();
            n++;
        end
        chk("t1_latency", 32'(n), 32'd2);
        chk("t1_grant_valid", 32'(grant_valid), 32'd1);
        busy_seen = 1'b0;
        n = 0;
        while (grant_valid && n < 50) begin
            cycle();
            if (tx_busy) busy_seen = 1'b1;
            n++;
        end
        chk("t1_released", 32'(grant_valid), 32'd0);
        chk("t1_busy_seen", 32'(busy_seen), 32'd1);
        chk("t1_busy_low_at_release", 32'(tx_busy), 32'd0);
        drain("t1", 50);
        chk("t1_one_start", 32'(tx_cnt - t0), 32'd1);
        chk("t1_no_timeout", 32'(to_cnt), 32'd0);

        // all four requesting, round-robin from reset
        reset_pulse();
        t0 = tx_cnt;
        pq[0].push_back({1'b1, 8'h30});
        pq[0].push_back({1'b1, 8'h30});
        for (int i = 1; i < N; i++) pq[i].push_back({1'b1, 8'(8'h30 + i)});
        exp_q.push_back({2'd0, 8'h30});
        exp_q.push_back({2'd1, 8'h31});
        exp_q.push_back({2'd2, 8'h32});
        exp_q.push_back({2'd3, 8'h33});
        exp_q.push_back({2'd0, 8'h30});
        drain("t2", 400);
        chk("t2_start_count", 32'(tx_cnt - t0), 32'd5);

        // packet lock: requester 2 sends "ABC" while requester 1 waits
        pq[1].push_back({1'b1, 8'h11});
        pq[1].push_back({1'b1, 8'h12});
        pq[2].push_back({1'b0, 8'h41});
        pq[2].push_back({1'b0, 8'h42});
        pq[2].push_back({1'b1, 8'h43});
        exp_q.push_back({2'd1, 8'h11});
        exp_q.push_back({2'd2, 8'h41});
        exp_q.push_back({2'd2, 8'h42});
        exp_q.push_back({2'd2, 8'h43});
        exp_q.push_back({2'd1, 8'h12});
        drain("t3", 400);

        // owner stalls mid-packet in HOLD; requester 3 waits for the abort
        to0 = to_cnt;
        pq[0].push_back({1'b0, 8'h55});
        exp_q.push_back({2'd0, 8'h55});
        wait_start("t4", 50);
        st = last_start_cyc;
        pq[3].push_back({1'b1, 8'h66});
        exp_q.push_back({2'd3, 8'h66});
        wait_timeout("t4", 1200);
        chk("t4_grant_dropped", 32'(grant_valid), 32'd0);
        chk("t4_hold_duration", 32'(last_to_cyc - st), 32'(TO + 14));
        drain("t4", 100);
        chk("t4_single_timeout", 32'(to_cnt - to0), 32'd1);

        // engine never goes busy
        eng_on = 1'b0;
        t0 = tx_cnt;
        pq[0].push_back({1'b1, 8'h77});
        exp_q.push_back({2'd0, 8'h77});
        wait_start("t5", 50);
        st = last_start_cyc;
        wait_timeout("t5", 1200);
        chk("t5_timeout_latency", 32'(last_to_cyc - st), 32'(TO));
        chk("t5_grant_dropped", 32'(grant_valid), 32'd0);
        repeat (5) cycle();
        chk("t5_no_retry", 32'(tx_cnt - t0), 32'd1);
        eng_on = 1'b1;

        // async reset in WAIT_DONE of a two-byte packet
        pq[1].push_back({1'b0, 8'h81});
        pq[1].push_back({1'b1, 8'h82});
        exp_q.push_back({2'd1, 8'h81});
        wait_start("t6", 50);
        n = 0;
        while (!tx_busy && n < 20) begin
            cycle();
            n++;
        end
        cycle();
        cycle();
        chk("t6_owned_before_rst", 32'(grant_valid), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_async_grant_valid", 32'(grant_valid), 32'd0);
        chk("t6_async_grant_id", {30'd0, grant_id}, 32'd0);
        chk("t6_async_tx_data", {24'd0, tx_data}, 32'd0);
        chk("t6_async_outputs", {29'd0, tx_start, timeout_err, |req_ready}, 32'd0);
        pq[1].delete();
        n = 0;
        while ((tx_busy || eng_pend) && n < 50) begin
            cycle();
            n++;
        end
        pq[0].push_back({1'b1, 8'h90});
        pq[1].push_back({1'b1, 8'h91});
        exp_q.push_back({2'd0, 8'h90});
        exp_q.push_back({2'd1, 8'h91});
        cycle();
        rst = 1'b1;
        drain("t6", 200);
        chk("t6_scoreboard_empty", 32'(exp_q.size()), 32'd0);
        chk("total_timeouts", 32'(to_cnt), 32'd2);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single UART transmit engine between NUM_REQ byte producers, e.g. a debug console, status reporter and loopback echo. Grants are round-robin and packet-locked: a requester keeps the transmitter until it has sent the byte flagged last. The block drives the engine's start/data inputs and sequences on its busy flag, with a watchdog for an engine that never responds.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 8, byte width
TIMEOUT, 1023, max cycles waited in WAIT_BUSY or HOLD before abort (fits 10-bit counter)

Ports:
clk  in  1  system clock (40 MHz)
rst  in  1  asynchronous, active-low reset
req_valid  in  NUM_REQ  requester i has a byte available
req_data  in  NUM_REQ*DATA_W  byte of requester i at bits [i*DATA_W +: DATA_W]
req_last  in  NUM_REQ  byte of requester i ends its packet
req_ready  out  NUM_REQ  one-cycle pulse: byte of requester i consumed
tx_start  out  1  one-cycle pulse to UART engine
tx_data  out  DATA_W  byte to engine, stable from tx_start until next tx_start
tx_busy  in  1  engine busy (start bit through stop bit)
grant_valid  out  1  a requester currently owns the engine
grant_id  out  $clog2(NUM_REQ)  owning requester
timeout_err  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset (rst low, async): state IDLE; req_ready=0, tx_start=0, tx_data=0, grant_valid=0, grant_id=0, timeout_err=0; rr_ptr=NUM_REQ-1, so requester 0 wins first; wdog=0.
- All outputs are registered. No combinational path from input to output.
- States: IDLE, SEND, WAIT_BUSY, WAIT_DONE, HOLD.
- IDLE: if any req_valid, select the first set bit searching rr_ptr+1, rr_ptr+2, ... modulo NUM_REQ. Register grant_id, set grant_valid=1, go to SEND. Otherwise stay.
- SEND (1 cycle):
  - tx_data<=req_data[grant_id]; tx_start=1; req_ready[grant_id]=1.
  - Latch last_flag<=req_last[grant_id]; wdog<=0; go to WAIT_BUSY.
  - Latency: req_valid sampled high in IDLE at edge N gives tx_start/req_ready high for the cycle after edge N+1.
- WAIT_BUSY: on tx_busy=1 go to WAIT_DONE. Else increment wdog; at wdog==TIMEOUT abort.
- WAIT_DONE: hold until tx_busy=0. Then:
  - last_flag=1: release (grant_valid=0), rr_ptr<=grant_id, go to IDLE.
  - last_flag=0 and req_valid[grant_id]=1: go to SEND.
  - last_flag=0 and req_valid[grant_id]=0: wdog<=0, go to HOLD.
- HOLD: packet open, waiting for the owner's next byte. Other requesters are ignored. On req_valid[grant_id]=1 go to SEND. Else increment wdog; at wdog==TIMEOUT abort.
- Abort: timeout_err=1 for 1 cycle; grant_valid=0; rr_ptr<=grant_id, so the offender goes last next round; go to IDLE. No req_ready is issued.
- Simultaneous requests: only the round-robin order decides. There is no fixed priority beyond rr_ptr.
- req_valid dropping while its owner is in SEND: not allowed. Producers hold valid/data/last until req_ready.
- tx_busy already high on entering WAIT_BUSY: accepted immediately.
- wdog saturates at TIMEOUT and never wraps.
- Reset mid-packet: outputs return to reset values asynchronously; a partially sent packet is dropped. Producers must tolerate this.
- req_ready is never high for more than one requester or for more than one cycle per byte.

Decomposition:
- Shared package uart_pkg holds:
  - the state enum constants (ST_IDLE..ST_HOLD, 3 bits);
  - the DATA_W default;
  - the TIMEOUT default.
- One sub-module, rr_pick: combinational round-robin selector. Inputs are the request vector and rr_ptr; outputs are found and idx. It is reusable by a future RX-side dispatcher.
- The FSM, the watchdog and the output registers stay in uart_tx_arbiter.

Test Plan:
- Reset then req_valid=4'b0001, data 0x47, last=1, engine model busy 3 cycles after start for 10 cycles -> tx_start 2 cycles after request, tx_data=0x47, req_ready[0] single pulse, grant_valid drops after busy falls, timeout_err never asserts.
- req_valid=4'b1111, every byte last=1, data=0x30+i -> transmit order 0x30,0x31,0x32,0x33,0x30, exactly one tx_start per busy period.
- Requester 2 sends 3-byte packet "ABC" (last only on 'C') while requester 1 holds valid throughout -> bytes A,B,C back to back with grant_id=2, then requester 1's byte.
- Requester 0 sends non-last byte then drops valid -> HOLD; after TIMEOUT=1023 cycles timeout_err pulses once, grant_valid=0, and the pending requester 3 is granted next.
- Engine model never raises tx_busy -> timeout_err exactly TIMEOUT cycles after tx_start, no second tx_start for that byte.
- Assert rst low during WAIT_DONE of a 2-byte packet -> all outputs 0 immediately (async), after release requester 0 is granted first.
